// File: rtl/bcm_readout_sequencer.sv
// rtl/bcm_readout_sequencer.sv - BCM accumulator readout sequencer with streaming output and running sum
//
// Walks the enabled accumulator channels word by word and sample by sample.
// For each sample it pulses the address strobe and waits for the
// clock-crossing settle time. It then captures the readout value and offers
// it on a valid/ready stream. Every accepted sample is added to a signed
// running sum.
//
// Ports:
//   sysClk, sysReset       system clock, synchronous active-high reset
//   sysCsrStrobe, GPIO_OUT command write: [31] start, [30] abort,
//                          [16+:CHANNEL_COUNT] channel mask, [0+:ADDRESS_WIDTH] last word address
//   sysAcqActive           accumulator acquisition in progress
//   sysReadoutReg          accumulator readout value (signed)
//   sysAddrStrobe          one-cycle address load strobe
//   sysAddrWord            {channel @24, word address, sample index @0}
//   outData/outChannel     captured sample and its channel
//   outValid/outReady      stream handshake, outLast marks the final word of a run
//   sysStatusReg           [31] busy, [30] error, [29] done, [16+] latched mask, [15:0] words emitted
//   sysRunSum              signed sum of all emitted samples of the current or last run
module bcm_readout_sequencer #(
    parameter int CHANNEL_COUNT     = 4,
    parameter int SAMPLES_PER_CLOCK = 4,
    parameter int ADDRESS_WIDTH     = 10,
    parameter int SETTLE_CYCLES     = 16,
    parameter int SUM_WIDTH         = 48
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic                        sysCsrStrobe,
    input  logic [31:0]                 GPIO_OUT,
    input  logic                        sysAcqActive,
    input  logic signed [31:0]          sysReadoutReg,
    output logic                        sysAddrStrobe,
    output logic [31:0]                 sysAddrWord,
    output logic signed [31:0]          outData,
    output logic [7:0]                  outChannel,
    output logic                        outValid,
    input  logic                        outReady,
    output logic                        outLast,
    output logic [31:0]                 sysStatusReg,
    output logic signed [SUM_WIDTH-1:0] sysRunSum
);

    localparam int SB = $clog2(SAMPLES_PER_CLOCK);
    localparam int CB = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [SB-1:0] SAMPLE_MAX  = SB'(SAMPLES_PER_CLOCK - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, STROBE, SETTLE, EMIT, ADVANCE} state_t;

    state_t                    state;
    logic                      busy, error, done;
    logic                      acqTorn;     // acquisition was seen active during the run
    logic [15:0]               count;
    logic [CHANNEL_COUNT-1:0]  mask;
    logic [ADDRESS_WIDTH-1:0]  lastAddr;
    logic [CB-1:0]             curChan, nextChan;
    logic [ADDRESS_WIDTH-1:0]  curAddr, nextAddr;
    logic [SB-1:0]             curSample, nextSample;
    logic [CW-1:0]             settleCnt;
    logic                      isLast;
    logic [CHANNEL_COUNT-1:0]  cmdMask;
    logic                      unused;

    assign cmdMask = GPIO_OUT[16 +: CHANNEL_COUNT];
    assign unused  = ^GPIO_OUT;

    function automatic logic [CB-1:0] lowestSet(input logic [CHANNEL_COUNT-1:0] m);
        logic [CB-1:0] r;
        r = '0;
        for (int i = CHANNEL_COUNT - 1; i >= 0; i--)
            if (m[i]) r = CB'(i);
        return r;
    endfunction

    function automatic logic [CB-1:0] highestSet(input logic [CHANNEL_COUNT-1:0] m);
        logic [CB-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++)
            if (m[i]) r = CB'(i);
        return r;
    endfunction

    // First enabled channel above cur; masked channels cost no cycles.
    function automatic logic [CB-1:0] nextSet(input logic [CHANNEL_COUNT-1:0] m, input logic [CB-1:0] cur);
        logic [CB-1:0] r;
        logic          found;
        r     = cur;
        found = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++)
            if (!found && i > int'(cur) && m[i]) begin
                r     = CB'(i);
                found = 1'b1;
            end
        return r;
    endfunction

    function automatic logic [31:0] makeWord(input logic [CB-1:0] ch, input logic [ADDRESS_WIDTH-1:0] ad,
                                             input logic [SB-1:0] s);
        logic [31:0] w;
        w = '0;
        w[0 +: SB]            = s;
        w[SB +: ADDRESS_WIDTH] = ad;
        w[24 +: CB]           = ch;
        return w;
    endfunction

    // Traversal: sample innermost, then address, then enabled channel.
    always_comb begin
        nextSample = curSample + 1'b1;
        nextAddr   = curAddr;
        nextChan   = curChan;
        if (curSample == SAMPLE_MAX) begin
            nextSample = '0;
            if (curAddr == lastAddr) begin
                nextAddr = '0;
                nextChan = nextSet(mask, curChan);
            end else begin
                nextAddr = curAddr + 1'b1;
            end
        end
    end

    assign isLast = (curChan == highestSet(mask)) && (curAddr == lastAddr) && (curSample == SAMPLE_MAX);

    always_comb begin
        sysStatusReg                     = '0;
        sysStatusReg[31]                 = busy;
        sysStatusReg[30]                 = error;
        sysStatusReg[29]                 = done;
        sysStatusReg[16 +: CHANNEL_COUNT] = mask;
        sysStatusReg[15:0]               = count;
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            error         <= 1'b0;
            done          <= 1'b0;
            acqTorn       <= 1'b0;
            count         <= '0;
            mask          <= '0;
            lastAddr      <= '0;
            curChan       <= '0;
            curAddr       <= '0;
            curSample     <= '0;
            settleCnt     <= '0;
            sysAddrStrobe <= 1'b0;
            sysAddrWord   <= '0;
            outData       <= '0;
            outChannel    <= '0;
            outValid      <= 1'b0;
            outLast       <= 1'b0;
            sysRunSum     <= '0;
        end else begin
            sysAddrStrobe <= 1'b0;
            if (busy && sysAcqActive) acqTorn <= 1'b1;

            if (sysCsrStrobe && GPIO_OUT[30]) begin
                // Abort wins over everything, including a start in the same write.
                state    <= IDLE;
                outValid <= 1'b0;
                busy     <= 1'b0;
                error    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (sysCsrStrobe && GPIO_OUT[31]) begin
                            if (sysAcqActive) begin
                                error <= 1'b1;
                            end else if (cmdMask == '0) begin
                                done      <= 1'b1;
                                error     <= 1'b0;
                                count     <= '0;
                                sysRunSum <= '0;
                            end else begin
                                mask          <= cmdMask;
                                lastAddr      <= GPIO_OUT[0 +: ADDRESS_WIDTH];
                                error         <= 1'b0;
                                done          <= 1'b0;
                                count         <= '0;
                                sysRunSum     <= '0;
                                busy          <= 1'b1;
                                acqTorn       <= 1'b0;
                                curChan       <= lowestSet(cmdMask);
                                curAddr       <= '0;
                                curSample     <= '0;
                                sysAddrWord   <= makeWord(lowestSet(cmdMask), '0, '0);
                                sysAddrStrobe <= 1'b1;
                                state         <= STROBE;
                            end
                        end
                    end
                    STROBE: begin
                        settleCnt <= SETTLE_LOAD;
                        state     <= SETTLE;
                    end
                    SETTLE: begin
                        if (settleCnt == '0) begin
                            outData    <= sysReadoutReg;
                            outChannel <= 8'(curChan);
                            outLast    <= isLast;
                            outValid   <= 1'b1;
                            state      <= EMIT;
                        end else begin
                            settleCnt <= settleCnt - 1'b1;
                        end
                    end
                    EMIT: begin
                        if (outReady) begin
                            outValid  <= 1'b0;
                            sysRunSum <= sysRunSum + {{(SUM_WIDTH-32){outData[31]}}, outData};
                            if (count != 16'hFFFF) count <= count + 16'd1;
                            if (outLast) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                // Acquisition during the run may have torn the data.
                                error <= acqTorn || sysAcqActive;
                            end else begin
                                state <= ADVANCE;
                            end
                        end
                    end
                    ADVANCE: begin
                        curChan       <= nextChan;
                        curAddr       <= nextAddr;
                        curSample     <= nextSample;
                        sysAddrWord   <= makeWord(nextChan, nextAddr, nextSample);
                        sysAddrStrobe <= 1'b1;
                        state         <= STROBE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcm_readout_sequencer.sv
// tb/tb_bcm_readout_sequencer.sv - scoreboard testbench for bcm_readout_sequencer
module tb_bcm_readout_sequencer;

    localparam int SETTLE = 4;

    logic               sysClk = 1'b0;
    logic               sysReset;
    logic               sysCsrStrobe;
    logic [31:0]        GPIO_OUT;
    logic               sysAcqActive;
    logic signed [31:0] sysReadoutReg;
    logic               sysAddrStrobe;
    logic [31:0]        sysAddrWord;
    logic signed [31:0] outData;
    logic [7:0]         outChannel;
    logic               outValid;
    logic               outReady;
    logic               outLast;
    logic [31:0]        sysStatusReg;
    logic signed [47:0] sysRunSum;

    bcm_readout_sequencer #(
        .CHANNEL_COUNT(4), .SAMPLES_PER_CLOCK(2), .ADDRESS_WIDTH(10),
        .SETTLE_CYCLES(SETTLE), .SUM_WIDTH(48)
    ) dut (
        .sysClk(sysClk), .sysReset(sysReset), .sysCsrStrobe(sysCsrStrobe), .GPIO_OUT(GPIO_OUT),
        .sysAcqActive(sysAcqActive), .sysReadoutReg(sysReadoutReg), .sysAddrStrobe(sysAddrStrobe),
        .sysAddrWord(sysAddrWord), .outData(outData), .outChannel(outChannel), .outValid(outValid),
        .outReady(outReady), .outLast(outLast), .sysStatusReg(sysStatusReg), .sysRunSum(sysRunSum)
    );

    always #5 sysClk = ~sysClk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  ch;
        logic        last;
    } word_t;

    word_t       expWords[$];
    logic [31:0] expAddrs[$];
    int          checks = 0;
    int          passes = 0;
    int          planWords;
    longint      planSum;
    int          valueMode = 0;
    logic [31:0] salt = 32'h1234_5678;
    int          strobeCount = 0;
    bit          readyRandom = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Accumulator contents as a function of {channel, address, sample}.
    function automatic logic [31:0] accValue(input logic [31:0] a);
        logic [31:0] c, ad, s;
        c  = {30'b0, a[25:24]};
        ad = {22'b0, a[10:1]};
        s  = {31'b0, a[0]};
        case (valueMode)
            1:       return (s == 0) ? 32'd5 : 32'hFFFF_FFFD;
            2:       return 32'h8000_0000;
            default: return salt ^ (c * 32'h9E37_79B9) ^ (ad * 32'h85EB_CA6B) ^ (s * 32'hC2B2_AE35);
        endcase
    endfunction

    function automatic logic [31:0] cmd(input logic st, input logic ab, input logic [3:0] m, input int last);
        logic [31:0] w;
        w = '0;
        w[31]    = st;
        w[30]    = ab;
        w[19:16] = m;
        w[9:0]   = last[9:0];
        return w;
    endfunction

    // Reference: enumerate enabled channels, then addresses 0..last, then samples.
    task automatic planRun(input logic [3:0] m, input int last);
        word_t w;
        expWords.delete();
        expAddrs.delete();
        planWords = 0;
        planSum   = 0;
        for (int c = 0; c < 4; c++)
            if (m[c])
                for (int a = 0; a <= last; a++)
                    for (int s = 0; s < 2; s++) begin
                        w.addr = (32'(c) << 24) | (32'(a) << 1) | 32'(s);
                        w.data = accValue(w.addr);
                        w.ch   = 8'(c);
                        w.last = 1'b0;
                        expWords.push_back(w);
                        expAddrs.push_back(w.addr);
                        planWords++;
                        planSum += longint'(signed'(w.data));
                    end
        if (planWords > 0) expWords[planWords-1].last = 1'b1;
    endtask

    // Accumulator model: readout is correct only in the capture cycle, SETTLE cycles after the strobe.
    int          accCnt = 100;
    logic [31:0] accWord = '0;
    logic        prevStrobe = 1'b0;
    always @(negedge sysClk) begin
        if (sysReset) begin
            accCnt     = 100;
            prevStrobe = 1'b0;
        end else begin
            if (sysAddrStrobe) begin
                strobeCount++;
                check("strobe_single_cycle", prevStrobe, 0);
                check("strobe_expected", 64'(expAddrs.size() != 0), 1);
                if (expAddrs.size() != 0) check("strobe_addr", sysAddrWord, expAddrs.pop_front());
                accWord = sysAddrWord;
                accCnt  = 0;
            end else if (accCnt < 100) begin
                accCnt++;
            end
            prevStrobe = sysAddrStrobe;
        end
        sysReadoutReg = (accCnt == SETTLE) ? accValue(accWord) : ~accValue(accWord);
    end

    // Output monitor: pops the scoreboard on every handshake.
    always @(negedge sysClk) begin
        word_t w;
        if (!sysReset && outValid && outReady) begin
            check("word_expected", 64'(expWords.size() != 0), 1);
            if (expWords.size() != 0) begin
                w = expWords.pop_front();
                check("word_data", $unsigned(outData), w.data);
                check("word_channel", outChannel, w.ch);
                check("word_last", outLast, w.last);
            end
        end
    end

    always @(posedge sysClk) begin
        #1;
        if (readyRandom) outReady = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic csrWrite(input logic [31:0] w);
        GPIO_OUT     = w;
        sysCsrStrobe = 1'b1;
        tick();
        sysCsrStrobe = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int acqAt, output int cyc);
        cyc = 0;
        while (sysStatusReg[31] && cyc < 5000) begin
            tick();
            cyc++;
            if (cyc == acqAt) sysAcqActive = 1'b1;
            if (cyc == acqAt + 5) sysAcqActive = 1'b0;
        end
        check({tag, "_finished"}, sysStatusReg[31], 0);
    endtask

    task automatic finalChecks(input string tag, input logic [3:0] m, input logic expErr);
        logic [47:0] sumExp;
        sumExp = planSum[47:0];
        check({tag, "_count"}, sysStatusReg[15:0], planWords[15:0]);
        check({tag, "_done"}, sysStatusReg[29], 1);
        check({tag, "_error"}, sysStatusReg[30], expErr);
        check({tag, "_mask"}, sysStatusReg[19:16], m);
        check({tag, "_sum"}, $unsigned(sysRunSum), sumExp);
        check({tag, "_words_left"}, expWords.size(), 0);
        check({tag, "_strobes_left"}, expAddrs.size(), 0);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_strobe"}, sysAddrStrobe, 0);
        check({tag, "_addr"}, sysAddrWord, 0);
        check({tag, "_data"}, $unsigned(outData), 0);
        check({tag, "_channel"}, outChannel, 0);
        check({tag, "_valid"}, outValid, 0);
        check({tag, "_last"}, outLast, 0);
        check({tag, "_status"}, sysStatusReg, 0);
        check({tag, "_sum"}, $unsigned(sysRunSum), 0);
    endtask

    initial begin
        int          cyc, sc, k;
        logic [31:0] held;
        logic [47:0] sumHeld;
        logic [3:0]  m;
        int          last;

        sysReset     = 1'b1;
        sysCsrStrobe = 1'b0;
        GPIO_OUT     = '0;
        sysAcqActive = 1'b0;
        outReady     = 1'b1;
        repeat (3) tick();
        checkAllZero("reset");
        sysReset = 1'b0;
        tick();

        // Full run over two non-adjacent channels, ready always high: 7 cycles per word.
        planRun(4'b0101, 3);
        sc = strobeCount;
        csrWrite(cmd(1, 0, 4'b0101, 3));
        check("t1_busy", sysStatusReg[31], 1);
        waitIdle("t1", -100, cyc);
        check("t1_cycles", cyc, 16 * 7 - 1);
        check("t1_strobes", strobeCount - sc, 16);
        finalChecks("t1", 4'b0101, 0);

        // Single channel 1, one address.
        planRun(4'b0010, 0);
        csrWrite(cmd(1, 0, 4'b0010, 0));
        waitIdle("t2", -100, cyc);
        finalChecks("t2", 4'b0010, 0);

        // Empty mask: done immediately, no strobe.
        sc = strobeCount;
        csrWrite(cmd(1, 0, 4'b0000, 2));
        check("mask0_done", sysStatusReg[29], 1);
        check("mask0_busy", sysStatusReg[31], 0);
        check("mask0_count", sysStatusReg[15:0], 0);
        check("mask0_sum", $unsigned(sysRunSum), 0);
        repeat (5) tick();
        check("mask0_no_strobe", strobeCount - sc, 0);

        // +5/-3 alternating over 8 words.
        valueMode = 1;
        planRun(4'b0001, 3);
        csrWrite(cmd(1, 0, 4'b0001, 3));
        waitIdle("alt", -100, cyc);
        finalChecks("alt", 4'b0001, 0);
        check("alt_sum_is_8", $unsigned(sysRunSum), 8);

        // Most negative readout value sign-extends into the sum.
        valueMode = 2;
        planRun(4'b1000, 0);
        csrWrite(cmd(1, 0, 4'b1000, 0));
        waitIdle("neg", -100, cyc);
        finalChecks("neg", 4'b1000, 0);
        check("neg_sum_sign", sysRunSum[47], 1);
        valueMode = 0;

        // Backpressure: hold outReady low for 10 cycles in EMIT.
        outReady = 1'b0;
        planRun(4'b0001, 0);
        csrWrite(cmd(1, 0, 4'b0001, 0));
        cyc = 0;
        while (!outValid && cyc < 100) begin tick(); cyc++; end
        check("bp_valid_seen", outValid, 1);
        held    = outData;
        sumHeld = sysRunSum;
        sc      = strobeCount;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_hold", outValid, 1);
            check("bp_data_hold", $unsigned(outData), held);
        end
        check("bp_no_strobe", strobeCount - sc, 0);
        check("bp_sum_hold", $unsigned(sysRunSum), sumHeld);
        outReady = 1'b1;
        waitIdle("bp", -100, cyc);
        finalChecks("bp", 4'b0001, 0);

        // Abort during SETTLE of the fifth word.
        planRun(4'b0001, 3);
        csrWrite(cmd(1, 0, 4'b0001, 3));
        k = 0;
        for (int n = 0; n < 500; n++) begin
            if (sysAddrStrobe) k++;
            if (k == 5) break;
            tick();
        end
        check("abort_reached_word5", k, 5);
        tick();
        csrWrite(cmd(0, 1, 4'b0000, 0));
        check("abort_busy", sysStatusReg[31], 0);
        check("abort_error", sysStatusReg[30], 1);
        check("abort_done", sysStatusReg[29], 0);
        check("abort_count", sysStatusReg[15:0], 4);
        check("abort_valid", outValid, 0);
        expWords.delete();
        expAddrs.delete();
        sc = strobeCount;
        repeat (8) tick();
        check("abort_no_strobe", strobeCount - sc, 0);

        // Start and abort in the same write: no run.
        csrWrite(cmd(1, 1, 4'b0001, 3));
        repeat (3) tick();
        check("startabort_no_strobe", strobeCount - sc, 0);
        check("startabort_busy", sysStatusReg[31], 0);
        check("startabort_error", sysStatusReg[30], 1);

        // Start while acquisition is active: error only.
        csrWrite(cmd(1, 0, 4'b0000, 0));
        check("clear_error", sysStatusReg[30], 0);
        sysAcqActive = 1'b1;
        csrWrite(cmd(1, 0, 4'b0011, 1));
        sysAcqActive = 1'b0;
        check("acq_error", sysStatusReg[30], 1);
        check("acq_busy", sysStatusReg[31], 0);
        check("acq_done_kept", sysStatusReg[29], 1);
        repeat (3) tick();
        check("acq_no_strobe", strobeCount - sc, 0);

        // Reset while a word waits in EMIT.
        outReady = 1'b0;
        planRun(4'b0001, 0);
        csrWrite(cmd(1, 0, 4'b0001, 0));
        cyc = 0;
        while (!outValid && cyc < 100) begin tick(); cyc++; end
        check("rst_valid_seen", outValid, 1);
        sysReset = 1'b1;
        tick();
        checkAllZero("rst_emit");
        sysReset = 1'b0;
        expWords.delete();
        expAddrs.delete();
        tick();

        // Randomized runs with random backpressure; one with acquisition rising mid-run.
        readyRandom = 1;
        for (int r = 0; r < 8; r++) begin
            salt = $urandom;
            m    = 4'($urandom_range(1, 15));
            last = $urandom_range(0, 3);
            if (r == 3) last = 3;
            planRun(m, last);
            csrWrite(cmd(1, 0, m, last));
            waitIdle("rand", (r == 3) ? 12 : -100, cyc);
            finalChecks("rand", m, r == 3);
            tick();
        end
        readyRandom = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
